// File: rtl/rv32i_pkg.sv
// Shared rv32i types: ALU/branch/memory op encodings, LSU exceptions,
// and the byte-lane helpers used by the load/store unit.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JMP
  } branch_type_e;

  typedef enum logic [3:0] {
    MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  typedef enum logic [1:0] {
    EXC_NONE, EXC_LD_MISALIGN, EXC_ST_MISALIGN, EXC_BUS_ERR
  } exc_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // 0 = byte, 1 = halfword, 2 = word
  function automatic logic [1:0] op_size(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 2'd0;
      MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
      default:                 return 2'd2;
    endcase
  endfunction

  function automatic logic misaligned(input mem_op_e op, input logic [1:0] off);
    return ((op_size(op) == 2'd1) && off[0]) || ((op_size(op) == 2'd2) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] lane_be(input mem_op_e op, input logic [1:0] off);
    case (op_size(op))
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input mem_op_e op, input logic [31:0] wdata);
    case (op_size(op))
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input mem_op_e op, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (op)
      MEM_LB:  return {{24{b[7]}}, b};
      MEM_LBU: return {24'h0, b};
      MEM_LH:  return {{16{h[15]}}, h};
      MEM_LHU: return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational lane steering for outgoing requests and extraction of
// returned load data.
module rv32i_lsu_align
  import rv32i_pkg::*;
(
  input  mem_op_e     req_op,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  input  mem_op_e     rsp_op,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] ldata
);

  assign be       = lane_be(req_op, req_off);
  assign wdata    = lane_wdata(req_op, req_wdata);
  assign misalign = misaligned(req_op, req_off);
  assign ldata    = load_extract(rsp_op, rsp_off, rsp_rdata);

endmodule

// File: rtl/rv32i_lsu.sv
// rv32i load/store unit: one data-bus transaction per accepted op, with a
// bus-error timeout. All outputs are registered.
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  mem_op_e     in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rdata,
  output exc_e        out_exc
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE} state_e;

  state_e      state;
  mem_op_e     op_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [15:0] cnt;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ldata_c;
  logic        misalign_c;
  logic [16:0] cnt_inc;
  logic        timeout_hit;

  // The cycle being counted now is the TIMEOUT-th one spent waiting.
  assign cnt_inc     = {1'b0, cnt} + 17'd1;
  assign timeout_hit = (cnt_inc >= 17'(TIMEOUT));

  rv32i_lsu_align u_align (
    .req_op    (in_op),
    .req_off   (in_addr[1:0]),
    .req_wdata (in_wdata),
    .rsp_op    (op_q),
    .rsp_off   (off_q),
    .rsp_rdata (mem_rdata),
    .be        (be_c),
    .wdata     (wdata_c),
    .misalign  (misalign_c),
    .ldata     (ldata_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      op_q      <= MEM_LB;
      off_q     <= 2'b00;
      rd_q      <= 5'd0;
      cnt       <= 16'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      out_valid <= 1'b0;
      out_rd    <= 5'd0;
      out_rdata <= 32'h0;
      out_exc   <= EXC_NONE;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            in_ready <= 1'b0;
            op_q     <= in_op;
            off_q    <= in_addr[1:0];
            rd_q     <= in_rd;
            cnt      <= 16'd0;
            if (misalign_c) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_rd    <= is_store(in_op) ? 5'd0 : in_rd;
              out_rdata <= 32'h0;
              out_exc   <= is_store(in_op) ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
            end else begin
              state     <= WAIT_GNT;
              mem_req   <= 1'b1;
              mem_we    <= is_store(in_op);
              mem_addr  <= {in_addr[31:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        WAIT_GNT: begin
          cnt <= cnt_inc[15:0];
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT_RSP;
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            state     <= DONE;
            out_valid <= 1'b1;
            out_rd    <= is_store(op_q) ? 5'd0 : rd_q;
            out_rdata <= 32'h0;
            out_exc   <= EXC_BUS_ERR;
          end
        end
        WAIT_RSP: begin
          cnt <= cnt_inc[15:0];
          if (mem_rvalid) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_rd    <= is_store(op_q) ? 5'd0 : rd_q;
            out_rdata <= is_store(op_q) ? 32'h0 : ldata_c;
            out_exc   <= EXC_NONE;
          end else if (timeout_hit) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_rd    <= is_store(op_q) ? 5'd0 : rd_q;
            out_rdata <= 32'h0;
            out_exc   <= EXC_BUS_ERR;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
